// File: rtl/final_soc_pio_out.sv
// Avalon-MM output PIO: software-written data register with atomic set/clear,
// a self-timed pulse mask OR-ed onto the pins, and 1-cycle registered readback.
module final_soc_pio_out #(
    parameter int unsigned           WIDTH        = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE  = '0,
    parameter int unsigned           PULSE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             pulse_busy
);

    localparam int unsigned CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_PULSE    = 2'd1;
    localparam logic [1:0] ADDR_OUTSET   = 2'd2;
    localparam logic [1:0] ADDR_OUTCLEAR = 2'd3;

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] pulse_mask_q, pulse_mask_d;
    logic [CW-1:0]    pulse_cnt_q, pulse_cnt_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             wr_s;
    logic [WIDTH-1:0] wd_s;
    logic             unused_wd_s;

    assign wr_s        = chipselect & ~write_n;
    assign wd_s        = writedata[WIDTH-1:0];
    assign unused_wd_s = ^writedata;

    // Next-state for data, pulse timer and readback.
    always_comb begin
        data_d       = data_q;
        pulse_mask_d = pulse_mask_q;
        pulse_cnt_d  = pulse_cnt_q;
        readdata_d   = 32'd0;

        if (wr_s) begin
            case (address)
                ADDR_DATA:     data_d = wd_s;
                ADDR_OUTSET:   data_d = data_q | wd_s;
                ADDR_OUTCLEAR: data_d = data_q & ~wd_s;
                default:       data_d = data_q;
            endcase
        end else begin
            data_d = data_q;
        end

        // A PULSE write beats expiry, so a retrigger always restarts the full width.
        if (wr_s && (address == ADDR_PULSE)) begin
            pulse_mask_d = wd_s;
            pulse_cnt_d  = CNT_LOAD;
        end else if (pulse_mask_q != '0) begin
            if (pulse_cnt_q != '0) begin
                pulse_cnt_d = pulse_cnt_q - CW'(1);
            end else begin
                pulse_mask_d = '0;
            end
        end else begin
            pulse_cnt_d = pulse_cnt_q;
        end

        case (address)
            ADDR_DATA:  readdata_d[WIDTH-1:0] = data_q;
            ADDR_PULSE: readdata_d[WIDTH-1:0] = pulse_mask_q;
            ADDR_OUTSET: readdata_d[0]        = |pulse_mask_q;
            default:    readdata_d            = 32'd0;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q       <= RESET_VALUE;
            pulse_mask_q <= '0;
            pulse_cnt_q  <= '0;
            readdata_q   <= 32'd0;
        end else begin
            data_q       <= data_d;
            pulse_mask_q <= pulse_mask_d;
            pulse_cnt_q  <= pulse_cnt_d;
            readdata_q   <= readdata_d;
        end
    end

    assign out_port   = data_q | pulse_mask_q;
    assign pulse_busy = |pulse_mask_q;
    assign readdata   = readdata_q;

endmodule
